// File: rtl/apb_timeout_guard_pkg.sv
// Shared types and defaults for the APB timeout guard.
package pkg_apb_timeout_guard;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    M_SETUP  = 2'd1,
    M_ACCESS = 2'd2,
    RESP     = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;
  localparam logic [31:0] DEFAULT_ERR_RDATA      = 32'hBADA_CCE5;

endpackage

// File: rtl/apb_timeout_guard_counter.sv
// Downstream ACCESS-cycle counter; flags the last cycle allowed before an abort.
module apb_timeout_counter
  import pkg_apb_timeout_guard::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic limit_reached
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count;

  // Cycle counter; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

  assign limit_reached = (count == LIMIT);

endmodule

// File: rtl/apb_timeout_guard.sv
// Registered APB stage that re-issues upstream transfers and aborts hung peripherals.
// Optional status ports are compiled in with APB_TIMEOUT_GUARD_STATUS_EN.
module apb_timeout_guard
  import pkg_apb_timeout_guard::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [DATA_WIDTH-1:0]  ERR_RDATA      = DATA_WIDTH'(DEFAULT_ERR_RDATA)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] s_paddr_i,
  input  logic                  s_psel_i,
  input  logic                  s_penable_i,
  input  logic                  s_pwrite_i,
  input  logic [DATA_WIDTH-1:0] s_pwdata_i,
  output logic [DATA_WIDTH-1:0] s_prdata_o,
  output logic                  s_pready_o,
  output logic                  s_pslverr_o,
  output logic [ADDR_WIDTH-1:0] m_paddr_o,
  output logic                  m_psel_o,
  output logic                  m_penable_o,
  output logic                  m_pwrite_o,
  output logic [DATA_WIDTH-1:0] m_pwdata_o,
  input  logic [DATA_WIDTH-1:0] m_prdata_i,
  input  logic                  m_pready_i,
  input  logic                  m_pslverr_i
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
  ,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  input  logic                  err_clear_i,
  output logic [15:0]           timeout_cnt_o
`endif
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_timeout_guard: TIMEOUT_CYCLES must be >= 1");
  end

  state_e                state;
  state_e                state_next;
  logic                  capture;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  limit_reached;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_counter (
    .clk           (clk_i),
    .rst           (rst_i),
    .clear         (state == RESP),
    .enable        (state == M_ACCESS),
    .limit_reached (limit_reached)
  );

  // Next-state and response selection; pready beats the timeout in the same cycle.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    case (state)
      IDLE: begin
        if (s_psel_i && !s_penable_i) begin
          state_next = M_SETUP;
          capture    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      M_SETUP: begin
        state_next = M_ACCESS;
      end
      M_ACCESS: begin
        if (m_pready_i) begin
          state_next = RESP;
          resp_rdata = m_prdata_i;
          resp_err   = m_pslverr_i;
        end else if (limit_reached) begin
          state_next  = RESP;
          resp_rdata  = ERR_RDATA;
          resp_err    = 1'b1;
          timeout_hit = 1'b1;
        end else begin
          state_next = M_ACCESS;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Every output is registered from the next state so nothing glitches onto either bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      m_paddr_o   <= '0;
      m_pwrite_o  <= 1'b0;
      m_pwdata_o  <= '0;
      m_psel_o    <= 1'b0;
      m_penable_o <= 1'b0;
      s_pready_o  <= 1'b0;
      s_prdata_o  <= '0;
      s_pslverr_o <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        m_paddr_o  <= s_paddr_i;
        m_pwrite_o <= s_pwrite_i;
        m_pwdata_o <= s_pwdata_i;
      end
      m_psel_o    <= (state_next == M_SETUP) || (state_next == M_ACCESS);
      m_penable_o <= (state_next == M_ACCESS);
      s_pready_o  <= (state_next == RESP);
      s_prdata_o  <= resp_rdata;
      s_pslverr_o <= resp_err;
    end
  end

`ifdef APB_TIMEOUT_GUARD_STATUS_EN
  // Sticky first-timeout capture (set beats clear) and saturating timeout total.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o   <= 1'b0;
      err_addr_o    <= '0;
      timeout_cnt_o <= 16'd0;
    end else begin
      if (timeout_hit) begin
        err_valid_o <= 1'b1;
        if (!err_valid_o || err_clear_i) begin
          err_addr_o <= m_paddr_o;
        end
      end else if (err_clear_i) begin
        err_valid_o <= 1'b0;
        err_addr_o  <= '0;
      end
      if (timeout_hit && (timeout_cnt_o != 16'hFFFF)) begin
        timeout_cnt_o <= timeout_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_apb_timeout_guard.sv
// Directed bench: dut_a uses the default timeout, dut_b uses TIMEOUT_CYCLES=4.
module tb_apb_timeout_guard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr, pwdata, m_prdata;
  logic        psel, penable, pwrite, m_pready, m_pslverr;
  logic        en_a, en_b;

  logic [31:0] a_s_prdata, a_m_paddr, a_m_pwdata;
  logic        a_s_pready, a_s_pslverr, a_m_psel, a_m_penable, a_m_pwrite;
  logic [31:0] b_s_prdata, b_m_paddr, b_m_pwdata;
  logic        b_s_pready, b_s_pslverr, b_m_psel, b_m_penable, b_m_pwrite;
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
  logic        err_clear;
  logic        a_err_valid, b_err_valid;
  logic [31:0] a_err_addr, b_err_addr;
  logic [15:0] a_timeout_cnt, b_timeout_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_timeout_guard dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_paddr_i   (paddr),
    .s_psel_i    (psel & en_a),
    .s_penable_i (penable),
    .s_pwrite_i  (pwrite),
    .s_pwdata_i  (pwdata),
    .s_prdata_o  (a_s_prdata),
    .s_pready_o  (a_s_pready),
    .s_pslverr_o (a_s_pslverr),
    .m_paddr_o   (a_m_paddr),
    .m_psel_o    (a_m_psel),
    .m_penable_o (a_m_penable),
    .m_pwrite_o  (a_m_pwrite),
    .m_pwdata_o  (a_m_pwdata),
    .m_prdata_i  (m_prdata),
    .m_pready_i  (m_pready),
    .m_pslverr_i (m_pslverr)
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
    ,
    .err_valid_o   (a_err_valid),
    .err_addr_o    (a_err_addr),
    .err_clear_i   (err_clear),
    .timeout_cnt_o (a_timeout_cnt)
`endif
  );

  apb_timeout_guard #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_paddr_i   (paddr),
    .s_psel_i    (psel & en_b),
    .s_penable_i (penable),
    .s_pwrite_i  (pwrite),
    .s_pwdata_i  (pwdata),
    .s_prdata_o  (b_s_prdata),
    .s_pready_o  (b_s_pready),
    .s_pslverr_o (b_s_pslverr),
    .m_paddr_o   (b_m_paddr),
    .m_psel_o    (b_m_psel),
    .m_penable_o (b_m_penable),
    .m_pwrite_o  (b_m_pwrite),
    .m_pwdata_o  (b_m_pwdata),
    .m_prdata_i  (m_prdata),
    .m_pready_i  (m_pready),
    .m_pslverr_i (m_pslverr)
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
    ,
    .err_valid_o   (b_err_valid),
    .err_addr_o    (b_err_addr),
    .err_clear_i   (err_clear),
    .timeout_cnt_o (b_timeout_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
    m_prdata = 32'd0; m_pready = 1'b0; m_pslverr = 1'b0; en_a = 1'b0; en_b = 1'b0;
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
    err_clear = 1'b0;
`endif
    tick(); tick();
    chk("rst_a_pready",  32'(a_s_pready),  32'd0);
    chk("rst_a_psel",    32'(a_m_psel),    32'd0);
    chk("rst_a_prdata",  a_s_prdata,       32'd0);
    chk("rst_b_pslverr", 32'(b_s_pslverr), 32'd0);
    chk("rst_b_paddr",   b_m_paddr,        32'd0);
    rst = 1'b0;

    // 1: read, zero wait states, both instances
    en_a = 1'b1; en_b = 1'b1; m_pready = 1'b1; m_prdata = 32'h1234_5678;
    psel = 1'b1; paddr = 32'h1A10_0010;
    tick(); penable = 1'b1;
    chk("rd_setup_psel",    32'(a_m_psel),    32'd1);
    chk("rd_setup_penable", 32'(a_m_penable), 32'd0);
    chk("rd_setup_paddr",   a_m_paddr,        32'h1A10_0010);
    chk("rd_setup_pready",  32'(a_s_pready),  32'd0);
    tick();
    chk("rd_access_penable", 32'(a_m_penable), 32'd1);
    chk("rd_access_pready",  32'(a_s_pready),  32'd0);
    tick();
    chk("rd_pready",   32'(a_s_pready),  32'd1);
    chk("rd_prdata",   a_s_prdata,       32'h1234_5678);
    chk("rd_pslverr",  32'(a_s_pslverr), 32'd0);
    chk("rd_b_pready", 32'(b_s_pready),  32'd1);
    chk("rd_b_prdata", b_s_prdata,       32'h1234_5678);
    tick(); psel = 1'b0; penable = 1'b0;
    chk("rd_pready_1cyc", 32'(a_s_pready), 32'd0);
    chk("rd_prdata_idle", a_s_prdata,      32'd0);
    en_b = 1'b0;

    // 2: write with five wait states on dut_a
    m_pready = 1'b0; psel = 1'b1; pwrite = 1'b1; paddr = 32'h1A10_0020; pwdata = 32'hCAFE_F00D;
    tick(); penable = 1'b1;
    chk("wr_pwdata", a_m_pwdata,      32'hCAFE_F00D);
    chk("wr_pwrite", 32'(a_m_pwrite), 32'd1);
    tick();
    for (int k = 1; k <= 6; k++) begin
      chk("wr_penable_hi", 32'(a_m_penable), 32'd1);
      chk("wr_no_early",   32'(a_s_pready),  32'd0);
      if (k == 6) m_pready = 1'b1;
      tick();
    end
    chk("wr_pready",     32'(a_s_pready),  32'd1);
    chk("wr_pslverr",    32'(a_s_pslverr), 32'd0);
    chk("wr_penable_lo", 32'(a_m_penable), 32'd0);
    m_pready = 1'b0;
    tick(); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;

    // 3: timeout on dut_b, then a late pready
    en_a = 1'b0; en_b = 1'b1; m_prdata = 32'h5555_AAAA; psel = 1'b1; paddr = 32'h1A10_0000;
    tick(); penable = 1'b1; tick();
    for (int k = 1; k <= 4; k++) begin
      chk("to_penable_hi", 32'(b_m_penable), 32'd1);
      chk("to_no_early",   32'(b_s_pready),  32'd0);
      tick();
    end
    chk("to_pready",  32'(b_s_pready),  32'd1);
    chk("to_pslverr", 32'(b_s_pslverr), 32'd1);
    chk("to_prdata",  b_s_prdata,       32'hBADA_CCE5);
    chk("to_psel_lo", 32'(b_m_psel),    32'd0);
    m_pready = 1'b1;
    tick(); psel = 1'b0; penable = 1'b0;
    chk("late_pready_1", 32'(b_s_pready), 32'd0);
    chk("late_prdata",   b_s_prdata,      32'd0);
    chk("late_psel",     32'(b_m_psel),   32'd0);
    tick();
    chk("late_pready_2", 32'(b_s_pready), 32'd0);
    m_pready = 1'b0;
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
    chk("st_valid_1", 32'(b_err_valid),   32'd1);
    chk("st_addr_1",  b_err_addr,         32'h1A10_0000);
    chk("st_cnt_1",   32'(b_timeout_cnt), 32'd1);
`endif

    // 4: pready arrives in the last allowed ACCESS cycle
    m_prdata = 32'hA5A5_0004; psel = 1'b1; paddr = 32'h1A10_0040;
    tick(); penable = 1'b1; tick();
    for (int k = 1; k <= 4; k++) begin
      chk("edge_no_early", 32'(b_s_pready), 32'd0);
      if (k == 4) m_pready = 1'b1;
      tick();
    end
    chk("edge_pready",  32'(b_s_pready),  32'd1);
    chk("edge_prdata",  b_s_prdata,       32'hA5A5_0004);
    chk("edge_pslverr", 32'(b_s_pslverr), 32'd0);
    m_pready = 1'b0;
    tick(); psel = 1'b0; penable = 1'b0;

`ifdef APB_TIMEOUT_GUARD_STATUS_EN
    // 6: second timeout keeps the first address, then clear
    chk("st_cnt_edge", 32'(b_timeout_cnt), 32'd1);
    psel = 1'b1; paddr = 32'h1A10_4000;
    tick(); penable = 1'b1; tick();
    repeat (4) tick();
    chk("st_to2_pslverr", 32'(b_s_pslverr), 32'd1);
    tick(); psel = 1'b0; penable = 1'b0;
    chk("st_valid_2", 32'(b_err_valid),   32'd1);
    chk("st_addr_2",  b_err_addr,         32'h1A10_0000);
    chk("st_cnt_2",   32'(b_timeout_cnt), 32'd2);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("st_valid_clr", 32'(b_err_valid),   32'd0);
    chk("st_addr_clr",  b_err_addr,         32'd0);
    chk("st_cnt_clr",   32'(b_timeout_cnt), 32'd2);
`endif

    // 5: back-to-back reads with psel held high
    en_a = 1'b1; en_b = 1'b0; m_pready = 1'b1; m_prdata = 32'h0000_1111;
    psel = 1'b1; paddr = 32'h1A10_0100;
    tick(); penable = 1'b1; tick(); tick();
    chk("b2b_pready_1", 32'(a_s_pready), 32'd1);
    chk("b2b_prdata_1", a_s_prdata,      32'h0000_1111);
    tick(); penable = 1'b0; paddr = 32'h1A10_0104; m_prdata = 32'h0000_2222;
    chk("b2b_gap_pready", 32'(a_s_pready), 32'd0);
    chk("b2b_gap_psel",   32'(a_m_psel),   32'd0);
    tick();
    chk("b2b_setup_psel",  32'(a_m_psel),    32'd1);
    chk("b2b_setup_paddr", a_m_paddr,        32'h1A10_0104);
    chk("b2b_setup_pen",   32'(a_m_penable), 32'd0);
    penable = 1'b1;
    tick(); tick();
    chk("b2b_pready_2", 32'(a_s_pready), 32'd1);
    chk("b2b_prdata_2", a_s_prdata,      32'h0000_2222);
    tick(); psel = 1'b0; penable = 1'b0;

    // reset in the middle of an ACCESS phase
    m_pready = 1'b0; psel = 1'b1; paddr = 32'h1A10_0200;
    tick(); penable = 1'b1; tick(); tick();
    chk("mid_penable", 32'(a_m_penable), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_psel",    32'(a_m_psel),    32'd0);
    chk("mid_rst_penable", 32'(a_m_penable), 32'd0);
    chk("mid_rst_paddr",   a_m_paddr,        32'd0);
    chk("mid_rst_pready",  32'(a_s_pready),  32'd0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_resp", 32'(a_s_pready), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
